// File: rtl/clut_loader.sv
// Palette loader: streams a palette image into the 3R ({G,R}) and 3S (B) palette RAMs.
// Writes are gated to vertical blanking and the image is closed by an 8-bit checksum byte.
module clut_loader #(
    parameter int ENTRIES     = 512,
    parameter int AW          = 9,
    parameter int GATE_VBLANK = 1
) (
    input  logic          CLK_6M,
    input  logic          CLR,
    input  logic          START,
    input  logic          ABORT,
    input  logic          VBLANK,
    input  logic [7:0]    DIN,
    input  logic          DIN_VALID,
    output logic          DIN_READY,
    output logic          RG_WE,
    output logic [AW-1:0] RG_WA,
    output logic [7:0]    RG_WD,
    output logic          B_WE,
    output logic [AW-1:0] B_WA,
    output logic [3:0]    B_WD,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [2:0]    STATE_DBG
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_RG = 3'd1,
        S_LOAD_B  = 3'd2,
        S_CHECK   = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRIES - 1);

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [7:0]    sum_q;
    logic [7:0]    sum_d;
    logic          rg_we_q;
    logic [AW-1:0] rg_wa_q;
    logic [7:0]    rg_wd_q;
    logic          b_we_q;
    logic [AW-1:0] b_wa_q;
    logic [3:0]    b_wd_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          loading;
    logic          last_entry;
    logic          xfer;

    // DIN handshake: a byte moves on a rising edge where DIN_VALID && DIN_READY.
    // DIN_READY depends only on state and VBLANK, never on DIN_VALID.
    always_comb begin
        loading    = (state_q == S_LOAD_RG) || (state_q == S_LOAD_B) || (state_q == S_CHECK);
        DIN_READY  = loading && (VBLANK || (GATE_VBLANK == 0));
        xfer       = DIN_VALID && DIN_READY;
        last_entry = (addr_q == LAST_ADDR);
        addr_d     = last_entry ? '0 : addr_q + 1'b1;
        sum_d      = sum_q + DIN;
    end

    always_ff @(posedge CLK_6M) begin
        if (CLR) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sum_q   <= '0;
            rg_we_q <= 1'b0;
            rg_wa_q <= '0;
            rg_wd_q <= '0;
            b_we_q  <= 1'b0;
            b_wa_q  <= '0;
            b_wd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rg_we_q <= 1'b0;
            b_we_q  <= 1'b0;
            if (ABORT && loading) begin
                // An abort swallows any coincident transfer: no strobe follows it.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                err_q   <= 1'b1;
            end else if (START && (state_q == S_IDLE || state_q == S_FINISH)) begin
                state_q <= S_LOAD_RG;
                addr_q  <= '0;
                sum_q   <= '0;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end else if (xfer) begin
                case (state_q)
                    S_LOAD_RG: begin
                        rg_we_q <= 1'b1;
                        rg_wa_q <= addr_q;
                        rg_wd_q <= DIN;
                        sum_q   <= sum_d;
                        addr_q  <= addr_d;
                        if (last_entry) state_q <= S_LOAD_B;
                    end
                    S_LOAD_B: begin
                        b_we_q <= 1'b1;
                        b_wa_q <= addr_q;
                        b_wd_q <= DIN[3:0];
                        sum_q  <= sum_d;
                        addr_q <= addr_d;
                        if (DIN[7:4] != 4'h0) err_q <= 1'b1;
                        if (last_entry) state_q <= S_CHECK;
                    end
                    S_CHECK: begin
                        // Trailer byte makes the mod-256 sum of the whole image zero.
                        sum_q   <= sum_d;
                        state_q <= S_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (sum_d != 8'h00) err_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign RG_WE     = rg_we_q;
    assign RG_WA     = rg_wa_q;
    assign RG_WD     = rg_wd_q;
    assign B_WE      = b_we_q;
    assign B_WA      = b_wa_q;
    assign B_WD      = b_wd_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_clut_loader.sv
// Bench for clut_loader: an ungated and a VBLANK-gated instance share stimulus;
// writes are scoreboarded against the byte stream, status against a checksum model.
module tb_clut_loader;

    localparam int N_ENT = 512;
    localparam int N_ALL = 2 * N_ENT + 1;
    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       vblank = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;

    logic       rdy0, rg_we0, b_we0, busy0, done0, err0;
    logic [8:0] rg_wa0, b_wa0;
    logic [7:0] rg_wd0;
    logic [3:0] b_wd0;
    logic [2:0] st0;
    logic       rdy1, rg_we1, b_we1, busy1, done1, err1;
    logic [8:0] rg_wa1, b_wa1;
    logic [7:0] rg_wd1;
    logic [3:0] b_wd1;
    logic [2:0] st1;

    logic       sel = 1'b0;
    logic       rdy, rg_we, b_we, busy, done, err;
    logic [8:0] rg_wa, b_wa;
    logic [7:0] rg_wd;
    logic [3:0] b_wd;
    logic [2:0] st;

    int checks = 0;
    int errors = 0;
    int gcyc = 0;
    int rg_cnt = 0;
    int b_cnt = 0;
    logic fmt_watch = 1'b0;
    logic [3:0] b7_val = 4'h0;
    logic vb_edge = 1'b0;

    logic [7:0]  stream [0:N_ALL-1];
    logic [16:0] exp_rg_q[$];
    logic [12:0] exp_b_q[$];
    logic [16:0] e_rg;
    logic [12:0] e_b;

    always #5 clk = ~clk;

    clut_loader #(.ENTRIES(512), .AW(9), .GATE_VBLANK(0)) dut0 (
        .CLK_6M(clk), .CLR(clr), .START(start), .ABORT(abort), .VBLANK(vblank),
        .DIN(din), .DIN_VALID(din_valid), .DIN_READY(rdy0),
        .RG_WE(rg_we0), .RG_WA(rg_wa0), .RG_WD(rg_wd0),
        .B_WE(b_we0), .B_WA(b_wa0), .B_WD(b_wd0),
        .BUSY(busy0), .DONE(done0), .ERR(err0), .STATE_DBG(st0));

    clut_loader #(.ENTRIES(512), .AW(9), .GATE_VBLANK(1)) dut1 (
        .CLK_6M(clk), .CLR(clr), .START(start), .ABORT(abort), .VBLANK(vblank),
        .DIN(din), .DIN_VALID(din_valid), .DIN_READY(rdy1),
        .RG_WE(rg_we1), .RG_WA(rg_wa1), .RG_WD(rg_wd1),
        .B_WE(b_we1), .B_WA(b_wa1), .B_WD(b_wd1),
        .BUSY(busy1), .DONE(done1), .ERR(err1), .STATE_DBG(st1));

    assign rdy   = sel ? rdy1   : rdy0;
    assign rg_we = sel ? rg_we1 : rg_we0;
    assign rg_wa = sel ? rg_wa1 : rg_wa0;
    assign rg_wd = sel ? rg_wd1 : rg_wd0;
    assign b_we  = sel ? b_we1  : b_we0;
    assign b_wa  = sel ? b_wa1  : b_wa0;
    assign b_wd  = sel ? b_wd1  : b_wd0;
    assign busy  = sel ? busy1  : busy0;
    assign done  = sel ? done1  : done0;
    assign err   = sel ? err1   : err0;
    assign st    = sel ? st1    : st0;

    always @(posedge clk) vb_edge <= vblank;

    // Scoreboard: every write strobe must match the next expected write, in order.
    always @(negedge clk) begin
        if (rg_we || b_we) begin
            checks++;
            if (rg_we && b_we) begin
                errors++;
                $display("FAIL we_exclusive: RG_WE=%0b B_WE=%0b required not both", rg_we, b_we);
            end
        end
        if (sel && (rg_we || b_we)) begin
            checks++;
            if (!vb_edge) begin
                errors++;
                $display("FAIL we_gated: write from an edge with VBLANK=%0b required 1", vb_edge);
            end
        end
        if (rg_we) begin
            rg_cnt++;
            checks++;
            if (exp_rg_q.size() == 0) begin
                errors++;
                $display("FAIL rg_write: unexpected write addr=%0d data=%02h", rg_wa, rg_wd);
            end else begin
                e_rg = exp_rg_q.pop_front();
                if ({rg_wa, rg_wd} !== e_rg) begin
                    errors++;
                    $display("FAIL rg_write: got addr=%0d data=%02h required addr=%0d data=%02h",
                             rg_wa, rg_wd, e_rg[16:8], e_rg[7:0]);
                end
            end
        end
        if (b_we) begin
            b_cnt++;
            checks++;
            if (b_wa == 9'd7) b7_val = b_wd;
            if (exp_b_q.size() == 0) begin
                errors++;
                $display("FAIL b_write: unexpected write addr=%0d data=%01h", b_wa, b_wd);
            end else begin
                e_b = exp_b_q.pop_front();
                if ({b_wa, b_wd} !== e_b) begin
                    errors++;
                    $display("FAIL b_write: got addr=%0d data=%01h required addr=%0d data=%01h",
                             b_wa, b_wd, e_b[12:4], e_b[3:0]);
                end
            end
            if (fmt_watch && b_wa >= 9'd7) begin
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL err_sticky: ERR=%0b at B entry %0d required 1", err, b_wa);
                end
            end
        end
    end

    // Reference model: stream position k lands in RG entry k, B entry k-512, or is the trailer.
    task automatic push_expected(input int k);
        logic [8:0] a;
        if (k < N_ENT) begin
            a = k[8:0];
            exp_rg_q.push_back({a, stream[k]});
        end else if (k < 2 * N_ENT) begin
            a = 9'(k - N_ENT);
            exp_b_q.push_back({a, stream[k][3:0]});
        end
    endtask

    function automatic logic model_err();
        logic [7:0] s;
        logic fmt;
        s = 8'h00;
        fmt = 1'b0;
        for (int i = 0; i < N_ALL; i++) begin
            s = s + stream[i];
            if (i >= N_ENT && i < 2 * N_ENT && stream[i][7:4] != 4'h0) fmt = 1'b1;
        end
        return (s != 8'h00) || fmt;
    endfunction

    task automatic build_stream(input bit rnd, input bit fmt_bad, input int delta);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 2 * N_ENT; i++) begin
            if (i < N_ENT) stream[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i % 256);
            else           stream[i] = rnd ? 8'($urandom_range(0, 15)) : 8'((i - N_ENT) % 16);
        end
        if (fmt_bad) stream[N_ENT + 7] = 8'h35;
        for (int i = 0; i < 2 * N_ENT; i++) s = s + stream[i];
        stream[2 * N_ENT] = 8'(8'h00 - s + 8'(delta));
    endtask

    function automatic logic vb_value(input int mode, input int c);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        if (c < 100) return 1'b0;
        return (((c - 100) / 20) % 2) == 0;
    endfunction

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        exp_rg_q.delete();
        exp_b_q.delete();
        rg_cnt = 0;
        b_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    // Drives stream[from..to-1]; with abort_at >= 0, ABORT rides on that byte's transfer.
    task automatic drive_range(input int from, input int to, input int vb_mode,
                               input bit rand_valid, input int abort_at);
        int idx;
        int cyc;
        bit aborted;
        idx = from;
        cyc = 0;
        aborted = 1'b0;
        while (idx < to && cyc < LIMIT) begin
            @(negedge clk);
            vblank = vb_value(vb_mode, gcyc);
            gcyc++;
            cyc++;
            din_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            din = stream[idx];
            #1;
            if (sel && !vblank) begin
                checks++;
                if (rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_gated: DIN_READY=%0b with VBLANK=0 required 0", rdy);
                end
            end
            if (din_valid && rdy) begin
                if (idx == abort_at) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                    break;
                end
                push_expected(idx);
                idx++;
            end
        end
        if (!aborted && idx < to) begin
            errors++;
            $display("FAIL stream_timeout: moved %0d bytes required %0d", idx - from, to - from);
        end
        @(negedge clk);
        din_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rg_we0, b_we0, busy0, done0, err0, rdy0, rg_we1, b_we1, busy1, done1, err1, rdy1} !== 12'h0) begin
            errors++;
            $display("FAIL reset_flags: got %03h required 000",
                     {rg_we0, b_we0, busy0, done0, err0, rdy0, rg_we1, b_we1, busy1, done1, err1, rdy1});
        end
        checks++;
        if ({rg_wa0, rg_wd0, b_wa0, b_wd0, rg_wa1, rg_wd1, b_wa1, b_wd1} !== 60'h0) begin
            errors++;
            $display("FAIL reset_bus: got %015h required 0",
                     {rg_wa0, rg_wd0, b_wa0, b_wd0, rg_wa1, rg_wd1, b_wa1, b_wd1});
        end
        checks++;
        if ({st0, st1} !== 6'h0) begin
            errors++;
            $display("FAIL reset_state: got %0d/%0d required IDLE(0)", st0, st1);
        end
        clr = 1'b0;
    endtask

    task automatic test_full_load(input bit bad_sum);
        logic exp_e;
        sel = 1'b0;
        do_clr();
        vblank = 1'b0;
        build_stream(1'b0, 1'b0, bad_sum ? 1 : 0);
        exp_e = model_err();
        pulse_start();
        checks++;
        if ({busy, done, err} !== 3'b100) begin
            errors++;
            $display("FAIL load_start: BUSY/DONE/ERR=%03b required 100", {busy, done, err});
        end
        gcyc = 0;
        drive_range(0, N_ALL, 0, 1'b1, -1);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, err} !== {1'b0, 1'b1, exp_e}) begin
            errors++;
            $display("FAIL load_end(bad=%0b): BUSY/DONE/ERR=%03b required %03b",
                     bad_sum, {busy, done, err}, {1'b0, 1'b1, exp_e});
        end
        checks++;
        if (rg_cnt != N_ENT || b_cnt != N_ENT || exp_rg_q.size() != 0 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL load_count(bad=%0b): rg=%0d b=%0d pending=%0d/%0d required 512/512 0/0",
                     bad_sum, rg_cnt, b_cnt, exp_rg_q.size(), exp_b_q.size());
        end
    endtask

    task automatic test_vblank_gating();
        sel = 1'b1;
        do_clr();
        vblank = 1'b0;
        build_stream(1'b1, 1'b0, 0);
        pulse_start();
        gcyc = 0;
        drive_range(0, N_ALL, 2, 1'b0, -1);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, err} !== {1'b0, 1'b1, model_err()}) begin
            errors++;
            $display("FAIL gate_end: BUSY/DONE/ERR=%03b required %03b", {busy, done, err}, {1'b0, 1'b1, model_err()});
        end
        checks++;
        if (rg_cnt != N_ENT || b_cnt != N_ENT || exp_rg_q.size() != 0 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL gate_count: rg=%0d b=%0d required 512/512", rg_cnt, b_cnt);
        end
    endtask

    task automatic test_format_err();
        sel = 1'b1;
        do_clr();
        build_stream(1'b1, 1'b1, 0);
        b7_val = 4'h0;
        fmt_watch = 1'b1;
        pulse_start();
        gcyc = 0;
        drive_range(0, N_ALL, 1, 1'b1, -1);
        repeat (2) @(negedge clk);
        #1;
        fmt_watch = 1'b0;
        checks++;
        if (b7_val !== 4'h5) begin
            errors++;
            $display("FAIL fmt_b7: B_WD at entry 7 = %01h required 5", b7_val);
        end
        checks++;
        if ({busy, done, err} !== {1'b0, 1'b1, model_err()}) begin
            errors++;
            $display("FAIL fmt_end: BUSY/DONE/ERR=%03b required 011", {busy, done, err});
        end
    endtask

    task automatic test_abort();
        sel = 1'b0;
        do_clr();
        build_stream(1'b1, 1'b0, 0);
        pulse_start();
        gcyc = 0;
        drive_range(0, N_ALL, 1, 1'b1, 300);
        #1;
        checks++;
        if ({busy, done, err} !== 3'b001) begin
            errors++;
            $display("FAIL abort_status: BUSY/DONE/ERR=%03b required 001", {busy, done, err});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rg_cnt != 300 || exp_rg_q.size() != 0) begin
            errors++;
            $display("FAIL abort_writes: rg writes=%0d required 300", rg_cnt);
        end
        pulse_start();
        checks++;
        if ({busy, done, err} !== 3'b100) begin
            errors++;
            $display("FAIL abort_restart: BUSY/DONE/ERR=%03b required 100", {busy, done, err});
        end
        drive_range(0, 5, 1, 1'b0, -1);
        repeat (2) @(negedge clk);
        checks++;
        if (rg_cnt != 305 || exp_rg_q.size() != 0) begin
            errors++;
            $display("FAIL abort_rewrite: rg writes=%0d required 305", rg_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        sel = 1'b0;
        do_clr();
        build_stream(1'b1, 1'b0, 0);
        pulse_start();
        gcyc = 0;
        drive_range(0, N_ENT + 8, 1, 1'b1, -1);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: BUSY=%0b after START during load required 1", busy);
        end
        drive_range(N_ENT + 8, N_ENT + 88, 1, 1'b1, -1);
        repeat (2) @(negedge clk);
        checks++;
        if (b_cnt != 88 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL start_ignored: b writes=%0d required 88", b_cnt);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if ({rg_we, b_we, busy, done, err, rdy, rg_wa, rg_wd, b_wa, b_wd, st} !== 39'h0) begin
            errors++;
            $display("FAIL clr_mid_load: outputs=%010h state=%0d required all 0", 
                     {rg_we, b_we, busy, done, err, rdy, rg_wa, rg_wd, b_wa, b_wd}, st);
        end
    endtask

    initial begin
        #5000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_load(1'b0);
        test_full_load(1'b1);
        test_vblank_gating();
        test_format_err();
        test_abort();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clut_loader.md
Name: clut_loader

Overview:
- Writer side of the colour lookup path: streams a palette image into the RAM copies of PROM 3R ({G,R} nibble pairs) and PROM 3S (B nibble) that feed the 8-bit index to RGB lookup.
- Palette RAMs are addressed {BANK, index}: 512 entries each.
- Sits between the boot/host byte source (valid/ready) and the two palette RAM write ports.
- Gates writes to vertical blanking and verifies a trailing 8-bit checksum.

Parameters:
- ENTRIES, 512, entries per palette RAM; must equal 2**AW.
- AW, 9, write-address width ({BANK, index[7:0]}).
- GATE_VBLANK, 1, 1 = accept bytes only while VBLANK high; 0 = accept at any time.

Ports:
- CLK_6M  input  1  pixel clock; all logic on rising edge.
- CLR  input  1  reset, synchronous, active-high.
- START  input  1  one-cycle pulse that begins a load.
- ABORT  input  1  cancels a load in progress.
- VBLANK  input  1  vertical blanking from video timing.
- DIN  input  8  stream byte.
- DIN_VALID  input  1  DIN valid.
- DIN_READY  output  1  loader accepts DIN this cycle.
- RG_WE  output  1  3R RAM write strobe.
- RG_WA  output  AW  3R RAM write address.
- RG_WD  output  8  3R write data {G[3:0], R[3:0]}.
- B_WE  output  1  3S RAM write strobe.
- B_WA  output  AW  3S RAM write address.
- B_WD  output  4  3S write data.
- BUSY  output  1  load in progress.
- DONE  output  1  load finished; sticky until next START or CLR.
- ERR  output  1  checksum, format or abort error; sticky until next START or CLR.

Behaviour:
- States: IDLE, LOAD_RG, LOAD_B, CHECK, FINISH.
- Reset (CLR high at edge): state IDLE; all outputs 0; address counter 0; checksum accumulator 0.
- Priority each cycle: CLR > ABORT > START > byte transfer.
- DIN_READY is combinational: 1 when state is LOAD_RG, LOAD_B or CHECK and (VBLANK or !GATE_VBLANK); otherwise 0.
- A transfer occurs on an edge where DIN_VALID && DIN_READY. The source may hold DIN_VALID high indefinitely; no byte is lost or duplicated across stalls.
- START in IDLE or FINISH:
  - next state LOAD_RG; addr = 0; sum = 0; DONE = 0; ERR = 0; BUSY = 1.
  - START in any other state is ignored.
- LOAD_RG:
  - each transfer registers RG_WA = addr, RG_WD = DIN, and RG_WE = 1 for exactly one cycle.
  - sum = (sum + DIN) mod 256; addr += 1.
  - on the transfer with addr = ENTRIES-1: addr wraps to 0 and state becomes LOAD_B.
- LOAD_B:
  - same as LOAD_RG, but drives B_WA, B_WD = DIN[3:0] and B_WE.
  - DIN[7:4] != 0 sets ERR (sticky); the write still occurs.
  - the full byte is added to sum.
  - after entry ENTRIES-1: addr = 0, state becomes CHECK.
- CHECK:
  - one trailer byte is accepted; no RAM write.
  - if (sum + trailer) mod 256 != 0, ERR = 1.
  - next state FINISH.
- FINISH: DONE = 1, BUSY = 0; remains until START or CLR.
- ABORT while BUSY:
  - next state IDLE; BUSY = 0; DONE = 0; ERR = 1.
  - no write strobe in the cycle following the abort edge, even if a transfer coincided.
  - ABORT in IDLE or FINISH has no effect.
- Write latency: one cycle from the transfer edge to the WE-high cycle. WE is never high two cycles for the same byte. RG_WE and B_WE are never high together.
- VBLANK falling mid-load: DIN_READY drops in the same cycle; the counter and sum hold; loading resumes at the next VBLANK with no gap in addresses.
- WA/WD hold their last values when WE = 0.

Test Plan:
- Full load, GATE_VBLANK = 0:
  - stimulus: START; bytes i mod 256 for RG, i mod 16 for B, then the correct trailer.
  - required: 512 RG_WE pulses with RG_WA 0..511 and RG_WD = i mod 256; 512 B_WE pulses with B_WD = i mod 16; DONE = 1, ERR = 0, BUSY = 0 after 1025 transfers.
- Bad checksum:
  - stimulus: same stream, trailer incremented by 1.
  - required: DONE = 1, ERR = 1; RAM writes identical to the full-load scenario.
- VBLANK gating, GATE_VBLANK = 1:
  - stimulus: VBLANK low for 100 cycles after START, then toggling 20 cycles high / 20 cycles low, DIN_VALID held high.
  - required: no DIN_READY or WE while VBLANK = 0; addresses contiguous across gaps; completes with DONE = 1.
- Format error:
  - stimulus: B-phase byte 0x35 at entry 7.
  - required: B_WA = 7 receives B_WD = 0x5; ERR sets and stays set; DONE = 1 at end.
- Abort:
  - stimulus: ABORT asserted coincident with the transfer of RG entry 300.
  - required: no write to address 300; next cycle BUSY = 0, ERR = 1, DONE = 0; a subsequent START restarts at RG_WA = 0 with ERR cleared.
- Reset:
  - stimulus: CLR mid-LOAD_B; START during BUSY.
  - required: CLR returns all outputs to 0 and state to IDLE on the next edge; START during BUSY does not reset addr.
